// File: rtl/vga_pkg.sv
// Shared VGA timing constants and RGB332 pixel helpers.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Bit replication so that full-scale codes map to 8'hFF and zero to 8'h00.
    function automatic logic [23:0] expand332(input rgb332_t p);
        return {p.r, p.r, p.r[2:1], p.g, p.g, p.g[2:1], p.b, p.b, p.b, p.b};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth synchronous shift register with a configurable reset value.
module vga_delay_line #(
    parameter int unsigned     WIDTH     = 1,
    parameter int unsigned     DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d[0] = data_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch stage: address generation, double-buffer swap control,
// RGB332 expansion and sync alignment with the fetched colour.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FB_W        = 160,
    parameter int unsigned FB_H        = 120,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_LAT     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        pixelX,
    input  logic [9:0]        pixelY,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              hsync,
    output logic              vsync,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue
);

    localparam int unsigned        LAT      = MEM_LAT + 2;
    localparam logic [ADDR_W-1:0] BUF_BASE = ADDR_W'(FB_W * FB_H);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              front_q, front_d;
    logic              pending_q, pending_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              vblank_start, do_swap, video_dly;

    assign vblank_start = (pixelX == 10'd0) && (pixelY == 10'(V_ACTIVE));
    assign do_swap      = vblank_start && (pending_q || swap_req);

    always_comb begin
        addr_d    = addr_q;
        front_d   = front_q;
        pending_d = pending_q;
        rgb_d     = expand332(rgb332_t'(mem_rdata));

        if (video_on) begin
            addr_d = (front_q ? BUF_BASE : '0)
                   + ADDR_W'(pixelY >> SCALE_SHIFT) * ADDR_W'(FB_W)
                   + ADDR_W'(pixelX >> SCALE_SHIFT);
        end

        // A request landing on the vblank-start cycle is folded into this swap.
        if (do_swap) begin
            front_d   = ~front_q;
            pending_d = 1'b0;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            rgb_q     <= rgb_d;
        end
    end

    // Syncs reset to inactive (high); video_on resets low so outputs stay blank
    // until the pipeline has refilled after reset.
    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (LAT),
        .RESET_VAL (3'b011)
    ) u_sync_dly (
        .clk_i  (clock),
        .rst_i  (reset),
        .data_i ({video_on, hsync_in, vsync_in}),
        .data_o ({video_dly, hsync, vsync})
    );

    assign mem_addr  = addr_q;
    assign front_buf = front_q;
    assign swap_ack  = do_swap && !reset;

    assign {red, green, blue} = video_dly ? rgb_q : 24'd0;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch against a cycle-history reference model.
module tb_vga_pixel_fetch;

    localparam int FBW = 160;
    localparam int BUF = 160 * 120;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixelX = '0, pixelY = '0;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, swap_req = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        swap_ack, front_buf, hsync, vsync;
    logic [7:0]  red, green, blue;

    logic [7:0]  ram [65536];
    logic [7:0]  rd1, rd2;

    typedef struct {
        bit vid;
        bit hs;
        bit vs;
        int addr;
    } ent_t;

    ent_t hist[$];
    int   m_addr;
    bit   m_front, m_pend;
    int   vectors = 0;
    int   miscompares = 0;

    always #20 clock = ~clock;

    // Framebuffer RAM with two cycles of read latency.
    always @(posedge clock) begin
        rd1 <= ram[mem_addr];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    vga_pixel_fetch dut (
        .clock     (clock),
        .reset     (reset),
        .pixelX    (pixelX),
        .pixelY    (pixelY),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .front_buf (front_buf),
        .hsync     (hsync),
        .vsync     (vsync),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    function automatic logic [23:0] ref_rgb(input logic [7:0] p);
        int r, g, b;
        r = int'(p) / 32;
        g = (int'(p) / 4) % 8;
        b = int'(p) % 4;
        return {8'((r * 32) + (r * 4) + (r / 2)),
                8'((g * 32) + (g * 4) + (g / 2)),
                8'(b * 85)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_hist();
        hist = {};
        repeat (4) hist.push_back('{vid: 1'b0, hs: 1'b1, vs: 1'b1, addr: 0});
    endtask

    // One clock: check the combinational ack, advance the model, then check registered outputs.
    task automatic cycle();
        bit         exp_ack;
        ent_t       e;
        logic [23:0] exp_rgb;
        #1;
        exp_ack = !reset && pixelX == 10'd0 && pixelY == 10'd480 && (m_pend || swap_req);
        chk("swap_ack", {31'd0, swap_ack}, {31'd0, exp_ack});
        if (reset) begin
            reset_hist();
            m_addr  = 0;
            m_front = 1'b0;
            m_pend  = 1'b0;
        end else begin
            if (video_on)
                m_addr = int'(m_front) * BUF + (int'(pixelY) / 4) * FBW + int'(pixelX) / 4;
            hist.push_back('{vid: video_on, hs: hsync_in, vs: vsync_in, addr: m_addr});
            void'(hist.pop_front());
            if (exp_ack) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        e       = hist[0];
        exp_rgb = e.vid ? ref_rgb(ram[e.addr]) : 24'd0;
        chk("mem_addr", {16'd0, mem_addr}, m_addr);
        chk("front_buf", {31'd0, front_buf}, {31'd0, m_front});
        chk("hsync", {31'd0, hsync}, {31'd0, e.hs});
        chk("vsync", {31'd0, vsync}, {31'd0, e.vs});
        chk("rgb", {8'd0, red, green, blue}, {8'd0, exp_rgb});
    endtask

    task automatic drive(input int x, input int y, input bit vid, input bit hs, input bit req);
        pixelX   = 10'(x);
        pixelY   = 10'(y);
        video_on = vid;
        hsync_in = hs;
        vsync_in = !(y >= 490 && y < 492);
        swap_req = req;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[321]   = 8'hE0;
        ram[19521] = 8'h1C;
        reset_hist();
        m_addr  = 0;
        m_front = 1'b0;
        m_pend  = 1'b0;

        // Reset held for three cycles.
        reset = 1'b1;
        repeat (3) cycle();
        chk("reset_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("reset_addr", {16'd0, mem_addr}, 32'd0);
        reset = 1'b0;

        // Address of pixel (5,9) in buffer 0, then colour and hsync four cycles later.
        drive(5, 9, 1'b1, 1'b0, 1'b0);
        chk("addr_buf0", {16'd0, mem_addr}, 32'd321);
        drive(6, 9, 1'b0, 1'b0, 1'b0);
        chk("hsync_early1", {31'd0, hsync}, 32'd1);
        drive(7, 9, 1'b0, 1'b0, 1'b0);
        chk("hsync_early2", {31'd0, hsync}, 32'd1);
        drive(8, 9, 1'b0, 1'b0, 1'b0);
        chk("lat_red", {24'd0, red}, 32'hFF);
        chk("lat_gb", {16'd0, green, blue}, 32'd0);
        chk("hsync_fall", {31'd0, hsync}, 32'd0);

        // Blanking: no colour while video_on is low, whatever RAM returns.
        ram[0] = 8'hFF;
        repeat (6) drive(700, 200, 1'b0, 1'b1, 1'b0);
        chk("blank_rgb", {8'd0, red, green, blue}, 32'd0);

        // Two requests in one frame merge into a single swap at vblank start.
        drive(10, 100, 1'b1, 1'b1, 1'b1);
        drive(11, 100, 1'b1, 1'b1, 1'b0);
        drive(12, 100, 1'b1, 1'b1, 1'b1);
        drive(640, 479, 1'b0, 1'b1, 1'b0);
        drive(0, 480, 1'b0, 1'b1, 1'b0);
        chk("swap_front1", {31'd0, front_buf}, 32'd1);
        drive(1, 480, 1'b0, 1'b1, 1'b0);
        chk("swap_once", {31'd0, front_buf}, 32'd1);

        // Buffer 1 address.
        drive(5, 9, 1'b1, 1'b1, 1'b0);
        chk("addr_buf1", {16'd0, mem_addr}, 32'd19521);
        repeat (3) drive(700, 9, 1'b0, 1'b1, 1'b0);

        // Request on the vblank-start cycle swaps immediately.
        drive(0, 480, 1'b0, 1'b1, 1'b1);
        chk("swap_same_cycle", {31'd0, front_buf}, 32'd0);

        // Randomised traffic, with occasional vblank-start cycles.
        for (int n = 0; n < 400; n++) begin
            bit vid;
            int x, y;
            vid = ($urandom_range(0, 3) != 0);
            x   = vid ? int'($urandom_range(0, 639)) : int'($urandom_range(640, 799));
            y   = vid ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 524));
            if ($urandom_range(0, 31) == 0) begin
                x = 0;
                y = 480;
            end
            drive(x, y, vid, 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        // Reset mid-frame with a swap pending: swap dropped, outputs blank for L cycles.
        drive(0, 479, 1'b0, 1'b1, 1'b0);
        drive(0, 480, 1'b0, 1'b1, 1'b0);
        drive(30, 300, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        repeat (2) drive(31, 300, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32 + k, 300, 1'b1, 1'b1, 1'b0);
            chk("post_reset_blank", {8'd0, red, green, blue}, 32'd0);
        end
        drive(40, 300, 1'b1, 1'b1, 1'b0);
        drive(0, 480, 1'b0, 1'b1, 1'b0);
        chk("dropped_swap", {31'd0, front_buf}, 32'd0);
        repeat (4) drive(1, 481, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
